// File: rtl/shift_reg_pkg.sv
// rtl/shift_reg_pkg.sv - shared constants and helpers for shift_reg_universal
// Contents: 3-bit mode encodings, FSM state type, shift-mode classifier.
package shift_reg_pkg;

    localparam logic [2:0] MODE_HOLD = 3'd0;
    localparam logic [2:0] MODE_LOAD = 3'd1;
    localparam logic [2:0] MODE_SHL  = 3'd2;
    localparam logic [2:0] MODE_SHR  = 3'd3;
    localparam logic [2:0] MODE_ROL  = 3'd4;
    localparam logic [2:0] MODE_ROR  = 3'd5;
    localparam logic [2:0] MODE_ASR  = 3'd6;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // True for the modes that a counted burst may repeat.
    function automatic logic is_shift_mode(input logic [2:0] m);
        return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) ||
               (m == MODE_ROR) || (m == MODE_ASR);
    endfunction

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational one-step next value of the shift register
// Ports: q (current value), mode, sin_l (enters MSB on SHR), sin_r (enters LSB
// on SHL), d (load data) -> q_next.
module shift_step
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       mode,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q_next
);

    always_comb begin
        q_next = q;
        case (mode)
            MODE_LOAD: q_next = d;
            MODE_SHL:  q_next = {q[WIDTH-2:0], sin_r};
            MODE_SHR:  q_next = {sin_l, q[WIDTH-1:1]};
            MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
            MODE_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
            default:   q_next = q;
        endcase
    end

endmodule

// File: rtl/shift_reg_universal.sv
// rtl/shift_reg_universal.sv - universal shift register with counted burst engine
// Ports: clock, clearb (async clear, active low), sclrb (sync clear, active low),
// en (single step), start/count (burst request), mode, d, sin_l, sin_r ->
// q, sout_l, sout_r, busy, done.
module shift_reg_universal
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             clearb,
    input  logic             sclrb,
    input  logic             en,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] count,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       mode_q, mode_d;
    logic [WIDTH-1:0] q_d;
    logic             done_d;
    logic [2:0]       step_mode;
    logic [WIDTH-1:0] step_q;

    // One step engine serves both paths: in RUN it repeats the latched mode,
    // in IDLE it follows the live mode input.
    assign step_mode = (state_q == ST_RUN) ? mode_q : mode;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .q      (q),
        .mode   (step_mode),
        .sin_l  (sin_l),
        .sin_r  (sin_r),
        .d      (d),
        .q_next (step_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        q_d     = q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_shift_mode(mode) && (count != '0)) begin
                        state_d = ST_RUN;
                        cnt_d   = count;
                        mode_d  = mode;
                    end else begin
                        // Degenerate request: only LOAD changes q, and
                        // completion is signalled immediately.
                        if (mode == MODE_LOAD) q_d = d;
                        done_d = 1'b1;
                    end
                end else if (en) begin
                    q_d = step_q;
                end
            end
            ST_RUN: begin
                q_d   = step_q;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clearb) begin
        if (!clearb) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= MODE_HOLD;
            q       <= '0;
            done    <= 1'b0;
        end else if (!sclrb) begin
            // Abort without a done pulse.
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= MODE_HOLD;
            q       <= '0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            q       <= q_d;
            done    <= done_d;
        end
    end

    assign busy   = (state_q == ST_RUN);
    assign sout_l = q[WIDTH-1];
    assign sout_r = q[0];

endmodule

// File: doc/shift_reg_universal.md
Name: shift_reg_universal

Overview:
- Parametrised successor to the single-bit clearable flip-flops: a WIDTH-bit register with load, shift, rotate and arithmetic-shift modes.
- Supports synchronous clear, asynchronous clear, and a counted burst-shift engine with busy/done handshake.
- Used as the general storage/shift element in datapath and serial-conversion logic.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- CNT_W, 4, width of the burst count; maximum burst length is 2^CNT_W-1.

Ports:
- clock  input  1  rising-edge clock.
- clearb  input  1  asynchronous active-low clear of all state.
- sclrb  input  1  synchronous active-low clear.
- en  input  1  single-step enable (IDLE only).
- start  input  1  burst request (IDLE only).
- mode  input  3  operation select: 0 HOLD, 1 LOAD, 2 SHL, 3 SHR, 4 ROL, 5 ROR, 6 ASR, 7 reserved (treated as HOLD).
- count  input  CNT_W  burst shift count, sampled with start.
- d  input  WIDTH  parallel load data.
- sin_l  input  1  serial in for SHR (enters the MSB).
- sin_r  input  1  serial in for SHL (enters the LSB).
- q  output  WIDTH  register contents.
- sout_l  output  1  q[WIDTH-1], combinational from q.
- sout_r  output  1  q[0], combinational from q.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset: clock is the only clock. clearb is asynchronous and active-low.
  - clearb low immediately forces q=0, state=IDLE, busy=0, done=0, internal counter=0.
  - It holds these values while low.
- Priority at each rising edge: clearb (async) > sclrb > FSM action.
- sclrb low at an edge: q=0, state=IDLE, done=0.
  - Aborts any burst without a done pulse.
- Step functions, one step each:
  - SHL: q={q[W-2:0],sin_r}
  - SHR: q={sin_l,q[W-1:1]}
  - ROL: q={q[W-2:0],q[W-1]}
  - ROR: q={q[0],q[W-1:1]}
  - ASR: q={q[W-1],q[W-1:1]}
  - LOAD: q=d
  - HOLD/7: q unchanged
- Serial inputs are sampled live on every shift edge, including within a burst.
- FSM states: IDLE, RUN.
- IDLE, start=1, mode in {SHL,SHR,ROL,ROR,ASR}, count!=0:
  - Latch mode and count; go to RUN.
  - q unchanged on this edge.
- IDLE, start=1 otherwise (count=0, or mode HOLD/LOAD/7):
  - Perform one step of mode (LOAD loads d; others hold).
  - done=1 for the next cycle; stay in IDLE.
- IDLE, start=0, en=1: one step of mode per edge. done stays 0.
- IDLE, start=0, en=0: hold.
- RUN:
  - One step of the latched mode per edge; the counter decrements.
  - On the edge performing the final (count-th) step, go to IDLE and set done=1 for exactly one cycle.
  - A burst of N therefore has busy high for N cycles, and done rises on the same edge busy falls.
  - start, en, mode, count and d are ignored in RUN.
- done is registered and is 0 in every cycle not listed above.
- start asserted in the cycle done is high is accepted normally (back-to-back bursts).

Decomposition:
- Package shift_reg_pkg holds:
  - mode constants MODE_HOLD..MODE_ASR (3-bit);
  - FSM state encoding ST_IDLE/ST_RUN;
  - a helper function returning whether a mode is a shift mode.
- One sub-module, shift_step: combinational next-value for (q, mode, sin_l, sin_r, d), parametrised by WIDTH. It is used by both the IDLE single-step path and the RUN path.

Test Plan:
- Load and rotate (WIDTH=8): en=1, mode=LOAD, d=0xA5 -> q=0xA5. Then ROL -> 0x4B, ROR -> 0xA5, ASR -> 0xD2, sout_l=1, sout_r=0.
- Burst SHL: q=0x81, start with mode=SHL, count=3, sin_r=1 -> q goes 0x03, 0x07, 0x0F on edges 1-3. busy=1 for 3 cycles, done=1 for exactly the cycle after edge 3.
- Burst ASR: q=0x90, count=2 -> q 0xC8 then 0xE4. A new start held high during RUN must be ignored until done.
- Zero/LOAD start: start with count=0, mode=SHL -> q unchanged, busy never 1, done pulses 1 cycle. start with mode=LOAD, d=0x3C -> q=0x3C and done pulses 1 cycle.
- Sync abort: burst of 5 SHR; sclrb low at edge 2 -> q=0, busy=0 after that edge, and done never asserts.
- Async clear mid-burst: clearb low between edges during RUN -> q=0, busy=0, done=0 before the next edge. Release, then a fresh burst works normally.
